// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO burst read engine.
package fifo_rd_pkg;
  localparam int DEF_WIDTH     = 128;
  localparam int DEF_BURST_LEN = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } rd_state_e;

  // Skid entry at the default word width.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 last;
  } skid_entry_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry registered skid buffer; entry 0 is always the head.
module fifo_rd_skid #(
  parameter int WIDTH = fifo_rd_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       occ
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } entry_t;

  entry_t ent [2];
  entry_t new_ent;
  logic   pop_ok, push_ok;

  assign new_ent   = '{data: push_data, last: push_last};
  assign pop_ok    = pop && (occ != 2'd0);
  assign push_ok   = push && ((occ != 2'd2) || pop_ok);
  assign out_valid = (occ != 2'd0);
  assign out_data  = ent[0].data;
  assign out_last  = ent[0].last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent[0] <= '0;
      ent[1] <= '0;
      occ    <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (occ == 2'd0) ent[0] <= new_ent;
          else             ent[1] <= new_ent;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent[0] <= ent[1];
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: the new word lands behind whatever remains.
          if (occ == 2'd1) begin
            ent[0] <= new_ent;
          end else begin
            ent[0] <= ent[1];
            ent[1] <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Burst-framed FIFO read engine with a 2-deep skid output.
// Optional beat counter enabled by defining FIFO_RD_STATS_EN.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             fifo_read_en,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]      beat_count
`endif
);
  localparam int             IW       = $clog2(BURST_LEN);
  localparam logic [IW-1:0]  LAST_IDX = IW'(BURST_LEN - 1);

  rd_state_e     state, state_nxt;
  logic [IW-1:0] burst_idx;
  logic [1:0]    occ;
  logic          xfer, wrap;

  assign fifo_read_en = (state != IDLE) && !fifo_empty && (occ < 2'd2);
  assign wrap         = fifo_read_en && (burst_idx == LAST_IDX);
  assign xfer         = m_valid && m_ready;
  assign busy         = (state != IDLE) || (occ != 2'd0);

  // Leaving RUN looks at the index after this cycle's pop, so a pop issued
  // while en falls still finishes its burst.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = ((burst_idx == '0 && !fifo_read_en) || wrap) ? IDLE : FINISH;
      FINISH:  if (en) state_nxt = RUN;
               else if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_idx <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_read_en) burst_idx <= wrap ? '0 : burst_idx + 1'b1;
    end
  end

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_read_en),
    .push_data (fifo_data_out),
    .push_last (burst_idx == LAST_IDX),
    .pop       (xfer),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_last  (m_last),
    .occ       (occ)
  );

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       beat_count <= '0;
    else if (xfer) beat_count <= beat_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed + random bench for fifo_burst_reader with a queue-based FIFO/stream model.
module tb_fifo_burst_reader;
  localparam int W  = 128;
  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         rst, en, m_ready, fifo_empty;
  logic [W-1:0] fifo_data_out;
  logic         fifo_read_en, m_valid, m_last, busy;
  logic [W-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]  beat_count;
`endif

  fifo_burst_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_read_en  (fifo_read_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy)
`ifdef FIFO_RD_STATS_EN
    ,
    .beat_count    (beat_count)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] q[$];     // words currently in the modelled FIFO
  logic [W-1:0] sent[$];  // words still owed to the output, in order
  int checks = 0, errors = 0;
  int dcount = 0, total = 0, inflight = 0;
  int pops = 0, xfers = 0, nlast = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  logic         hold_pend = 1'b0, hold_last;
  logic [W-1:0] hold_data;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty    = (q.size() == 0);
    fifo_data_out = (q.size() == 0) ? '0 : q[0];
  endtask

  task automatic push(input logic [W-1:0] w);
    q.push_back(w);
    sent.push_back(w);
    refresh();
  endtask

  function automatic logic [W-1:0] rword();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a falling edge with inputs set; sample, cross one rising edge, update model.
  task automatic step();
    logic rd, xf;
    #1;
    rd = fifo_read_en;
    xf = m_valid && m_ready;
    if (rd) begin
      chk("pop_on_empty", fifo_empty, 1'b0);
      chk("occ_bound", inflight < 2, 1'b1);
    end
    if (hold_pend) begin
      chk("hold_data", m_data, hold_data);
      chk("hold_last", m_last, hold_last);
    end
    if (xf) begin
      checks++;
      assert (sent.size() != 0) else begin
        errors++;
        $error("FAIL extra_beat: got %0h expected none", m_data);
      end
      if (sent.size() != 0) chk("beat_data", m_data, sent.pop_front());
      chk("beat_last", m_last, (dcount % BL) == BL - 1);
      if (m_last) nlast++;
      if (xfers == 0) first_cyc = cyc;
      last_cyc = cyc;
      dcount++; total++; xfers++;
    end
    hold_pend = m_valid && !m_ready;
    hold_data = m_data;
    hold_last = m_last;
    @(posedge clk);
    @(negedge clk);
    if (rd) begin
      void'(q.pop_front());
      pops++;
    end
    inflight = inflight + int'(rd) - int'(xf);
    cyc++;
    refresh();
  endtask

  task automatic run_deliver(input int n, input int budget);
    int b = budget;
    while (xfers < n && b > 0) begin step(); b--; end
    checks++;
    assert (xfers >= n) else begin
      errors++;
      $error("FAIL deliver_timeout: got %0d beats expected %0d", xfers, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    while (busy && b > 0) begin step(); b--; end
    #1 chk("idle", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    refresh();
    @(negedge clk); #1;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_rd", fifo_read_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_data", m_data, '0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous stream of two bursts
    for (int i = 0; i < 32; i++) push(rword());
    en = 1'b1; m_ready = 1'b1; xfers = 0; pops = 0; nlast = 0;
    run_deliver(32, 100);
    en = 1'b0;
    wait_idle(20);
    chk("stream_tput", last_cyc - first_cyc, 31);
    chk("stream_pops", pops, 32);
    chk("stream_lasts", nlast, 2);

    // en withdrawn mid-burst
    for (int i = 0; i < 32; i++) push(rword());
    en = 1'b1; xfers = 0; pops = 0;
    run_deliver(6, 50);
    en = 1'b0;
    wait_idle(100);
    chk("stop_beats", xfers, 16);
    chk("stop_left", q.size(), 16);
    en = 1'b1; xfers = 0;
    run_deliver(16, 60);
    en = 1'b0;
    wait_idle(20);

    // Back-pressure right after start
    for (int i = 0; i < 32; i++) push(rword());
    m_ready = 1'b0; en = 1'b1; pops = 0;
    for (int i = 0; i < 12; i++) step();
    #1;
    chk("bp_pops", pops, 2);
    chk("bp_head", m_data, sent[0]);
    chk("bp_valid", m_valid, 1'b1);
    m_ready = 1'b1; xfers = 0;
    run_deliver(32, 100);
    en = 1'b0;
    wait_idle(20);

    // FIFO runs dry mid-burst
    for (int i = 0; i < 7; i++) push(rword());
    en = 1'b1; xfers = 0; nlast = 0;
    run_deliver(7, 40);
    pops = 0;
    for (int i = 0; i < 5; i++) step();
    chk("gap_pops", pops, 0);
    for (int i = 0; i < 3; i++) push(rword());
    run_deliver(10, 40);
    for (int i = 0; i < 6; i++) push(rword());
    run_deliver(16, 40);
    en = 1'b0;
    wait_idle(20);
    chk("gap_lasts", nlast, 1);

    // Asynchronous reset while the buffer holds two beats
    for (int i = 0; i < 32; i++) push(rword());
    m_ready = 1'b0; en = 1'b1; pops = 0;
    for (int b = 0; b < 10 && pops < 2; b++) step();
    #1 chk("pre_rst_valid", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_rd", fifo_read_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    sent = q;
    dcount = 0; total = 0; inflight = 0; hold_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push(rword()); push(rword());
    m_ready = 1'b1; xfers = 0;
    run_deliver(32, 100);
    en = 1'b0;
    wait_idle(20);

    // Random traffic with en toggling and random back-pressure
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 15) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && q.size() < 1000) push(rword());
      step();
    end
    en = 1'b0; m_ready = 1'b1;
    for (int b = 0; b < 300 && busy; b++) begin
      if (q.size() == 0) push(rword());
      step();
    end
    #1 chk("rand_idle", busy, 1'b0);
    chk("rand_boundary", dcount % BL, 0);
`ifdef FIFO_RD_STATS_EN
    chk("stats_rand", beat_count, total);
    rst = 1'b1;
    #1 chk("stats_rst", beat_count, 32'd0);
    sent = q; dcount = 0; total = 0; inflight = 0; hold_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 48; i++) push(rword());
    en = 1'b1; m_ready = 1'b1; xfers = 0;
    run_deliver(40, 100);
    m_ready = 1'b0;
    #1 chk("stats_40", beat_count, 32'd40);
    rst = 1'b1;
    #1 chk("stats_rst2", beat_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
